// File: rtl/maxpool2x2_column.sv
// Streaming 2x2 max-pool: buffers an even column, pools it with the following odd column,
// and emits COLUMN_SIZE/2 registered signed maxima, flagging the last pooled column of each map.
module maxpool2x2_column #(
    parameter int COLUMN_SIZE = 24,
    parameter int MAP_WIDTH   = 24
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [COLUMN_SIZE-1:0][15:0]      data_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [COLUMN_SIZE/2-1:0][15:0]    data_out,
    output logic                              out_last
);

    localparam int POOLED_COLS = MAP_WIDTH / 2;
    localparam int IDX_W       = (POOLED_COLS > 1) ? $clog2(POOLED_COLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POOLED_COLS - 1);

    typedef enum logic [1:0] {
        S_FIRST,
        S_SECOND,
        S_OUT
    } state_t;

    state_t                             state_q, state_d;
    logic [COLUMN_SIZE-1:0][15:0]       col_buf_q, col_buf_d;
    logic [COLUMN_SIZE/2-1:0][15:0]     data_out_q, data_out_d;
    logic                               out_last_q, out_last_d;
    logic [IDX_W-1:0]                   pool_idx_q, pool_idx_d;
    logic                               in_xfer;

    function automatic logic [15:0] max2(input logic [15:0] a, input logic [15:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    // S_OUT only accepts a new column when the pending result leaves in the same cycle
    assign in_ready  = !rst && ((state_q != S_OUT) || out_ready);
    assign out_valid = (state_q == S_OUT);
    assign data_out  = data_out_q;
    assign out_last  = out_last_q;
    assign in_xfer   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        col_buf_d  = col_buf_q;
        data_out_d = data_out_q;
        out_last_d = out_last_q;
        pool_idx_d = pool_idx_q;
        case (state_q)
            S_FIRST: begin
                if (in_xfer) begin
                    col_buf_d = data_in;
                    state_d   = S_SECOND;
                end
            end
            S_SECOND: begin
                if (in_xfer) begin
                    for (int k = 0; k < COLUMN_SIZE / 2; k++) begin
                        data_out_d[k] = max2(max2(col_buf_q[2*k], col_buf_q[2*k+1]),
                                             max2(data_in[2*k], data_in[2*k+1]));
                    end
                    out_last_d = (pool_idx_q == LAST_IDX);
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    pool_idx_d = out_last_q ? '0 : pool_idx_q + 1'b1;
                    if (in_xfer) begin
                        col_buf_d = data_in;
                        state_d   = S_SECOND;
                    end else begin
                        state_d   = S_FIRST;
                    end
                end
            end
            default: state_d = S_FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FIRST;
            data_out_q <= '0;
            out_last_q <= 1'b0;
            pool_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            out_last_q <= out_last_d;
            pool_idx_q <= pool_idx_d;
        end
    end

    // The column buffer needs no reset: it is always written before it is read
    always_ff @(posedge clk) begin
        col_buf_q <= col_buf_d;
    end

endmodule

// File: tb/tb_maxpool2x2_column.sv
// Testbench for maxpool2x2_column: directed and random column streams checked against
// a pair-based max-pool reference model with an expected-output queue.
module tb_maxpool2x2_column;

    localparam int CS = 4;
    localparam int MW = 24;
    localparam int POOLED = MW / 2;

    typedef logic [CS-1:0][15:0]   col_t;
    typedef logic [CS/2-1:0][15:0] pcol_t;
    typedef struct packed {
        pcol_t d;
        logic  last;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  in_valid;
    logic  in_ready;
    col_t  data_in;
    logic  out_valid;
    logic  out_ready;
    pcol_t data_out;
    logic  out_last;

    int    pass_cnt = 0;
    int    total_cnt = 0;
    exp_t  exp_q[$];
    col_t  even_col;
    bit    have_even = 0;
    int    pair_cnt = 0;
    bit    last_xfer = 0;
    int    dut_lasts = 0;

    maxpool2x2_column #(.COLUMN_SIZE(CS), .MAP_WIDTH(MW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Each pooled value is the largest of four signed integers
    function automatic pcol_t pool(input col_t e, input col_t o);
        pcol_t r;
        for (int k = 0; k < CS / 2; k++) begin
            int cand[4];
            int best;
            cand[0] = int'($signed(e[2*k]));
            cand[1] = int'($signed(e[2*k+1]));
            cand[2] = int'($signed(o[2*k]));
            cand[3] = int'($signed(o[2*k+1]));
            best = cand[0];
            for (int j = 1; j < 4; j++) if (cand[j] > best) best = cand[j];
            r[k] = 16'(best);
        end
        return r;
    endfunction

    function automatic col_t mk(input int a, input int b, input int c, input int d);
        col_t x;
        x[0] = 16'(a); x[1] = 16'(b); x[2] = 16'(c); x[3] = 16'(d);
        return x;
    endfunction

    function automatic col_t rand_col();
        col_t x;
        for (int i = 0; i < CS; i++) x[i] = 16'($urandom);
        return x;
    endfunction

    task automatic model_in(input col_t c);
        exp_t e;
        if (!have_even) begin
            even_col  = c;
            have_even = 1;
        end else begin
            e.d       = pool(even_col, c);
            e.last    = ((pair_cnt % POOLED) == POOLED - 1);
            pair_cnt++;
            have_even = 0;
            exp_q.push_back(e);
        end
    endtask

    // Called just after a negedge with inputs driven; returns at the next negedge
    task automatic step();
        bit had_out;
        #1;
        had_out = (exp_q.size() > 0);
        chk("out_valid", out_valid, had_out);
        if (had_out && out_valid) begin
            chk("data_out", data_out, exp_q[0].d);
            chk("out_last", out_last, exp_q[0].last);
        end
        chk("in_ready", in_ready, !had_out || out_ready);
        last_xfer = in_valid && in_ready;
        if (out_valid && out_ready && out_last) dut_lasts++;
        if (had_out && out_ready) void'(exp_q.pop_front());
        if (in_valid && in_ready) model_in(data_in);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input col_t c);
        int n;
        in_valid = 1'b1;
        data_in  = c;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_xfer && n < 100);
        chk("push_done", last_xfer, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("in_ready_in_reset", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        have_even = 0;
        pair_cnt  = 0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_data_out", data_out, '0);
        chk("rst_out_last", out_last, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        @(negedge clk);
        do_reset();

        // Basic pool
        push(mk(1, 5, 2, 3));
        push(mk(4, 0, 7, 6));
        #1 chk("basic_const", data_out, {16'd7, 16'd5});
        step();
        step();

        // Signed compare: 0x8000 must never win
        push(mk(-3, -8, 'h7FFF, -1));
        push(mk(-5, -2, 'h8000, 0));
        #1 chk("signed_const", data_out, {16'h7FFF, 16'hFFFE});
        step();

        // Back-pressure with a concurrent input on release
        push(mk(11, 12, 13, 14));
        push(mk(21, 22, 23, 24));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = mk(31, -32, 33, 34);
        for (int i = 0; i < 5; i++) step();
        out_ready = 1'b1;
        step();
        chk("bp_release_xfer", last_xfer, 1'b1);
        push(mk(41, 42, -43, 44));
        step();
        step();

        // Full map x2 from a clean pool index
        do_reset();
        dut_lasts = 0;
        for (int c = 0; c < 2 * MW; c++) push(mk(10*c, 10*c+1, 10*c+2, 10*c+3));
        step();
        step();
        chk("map_last_count", dut_lasts, 2);

        // Reset mid-pair, then a fresh map's worth of random pairs
        push(rand_col());
        do_reset();
        dut_lasts = 0;
        for (int c = 0; c < MW + 2; c++) push(rand_col());
        step();
        step();
        chk("post_reset_last_count", dut_lasts, 1);

        // Upstream stall between even and odd columns
        push(rand_col());
        for (int i = 0; i < 10; i++) step();
        push(rand_col());
        step();
        step();

        // Random valid/ready traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            data_in   = rand_col();
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
